// File: rtl/vm_controller.sv
// rtl/vm_controller.sv - vending-machine transaction controller: credit, stock, vend and greedy change return
package vm2002_pkg;
    typedef enum logic [1:0] {
        NICKEL      = 2'd0,
        DIME        = 2'd1,
        QUARTER     = 2'd2,
        ILLEGALCOIN = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        AVAILABE    = 2'd0,
        UNAVAILABLE = 2'd1,
        ERROR       = 2'd2
    } status_t;
endpackage

module vm_controller
    import vm2002_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 8,
    parameter int                            CREDIT_W   = 8,
    parameter int                            STOCK_W    = 4,
    parameter int                            INIT_STOCK = 10,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     =
        {8'd35, 8'd30, 8'd25, 8'd20, 8'd40, 8'd20, 8'd20, 8'd10}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  coin_t                        coin,
    output logic                         coin_reject,
    input  logic                         select_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] select,
    input  logic                         cancel,
    input  logic                         restock_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
    input  logic [STOCK_W-1:0]           restock_qty,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         dispense_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
    output logic                         change_valid,
    output coin_t                        change_coin,
    output status_t                      status,
    output logic                         busy,
    output logic [NUM_ITEMS-1:0]         stock_empty
);

    localparam int                  SEL_W     = $clog2(NUM_ITEMS);
    localparam logic [STOCK_W-1:0]  STOCK_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock     [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_next[NUM_ITEMS];
    logic [STOCK_W:0]    stock_sum;
    logic [SEL_W-1:0]    vend_item;
    logic [CREDIT_W-1:0] credit_next;
    status_t             status_next;
    logic                reject_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
            assign price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
        end
    endgenerate

    function automatic logic [CREDIT_W-1:0] coin_value(input coin_t c);
        case (c)
            NICKEL:  coin_value = CREDIT_W'(1);
            DIME:    coin_value = CREDIT_W'(2);
            QUARTER: coin_value = CREDIT_W'(5);
            default: coin_value = '0;
        endcase
    endfunction

    function automatic coin_t greedy_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= CREDIT_W'(5))
            greedy_coin = QUARTER;
        else if (amt >= CREDIT_W'(2))
            greedy_coin = DIME;
        else
            greedy_coin = NICKEL;
    endfunction

    logic                idle_like;
    logic                coin_arb;
    logic                coin_accept;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_empty;
    logic                sel_poor;
    logic                sel_ok;
    logic [CREDIT_W-1:0] vend_rem;
    logic [CREDIT_W-1:0] change_rem;

    // Arbitration among front-end strobes: cancel beats select beats coin.
    assign idle_like   = (state == S_IDLE) || (state == S_CREDIT);
    assign coin_arb    = idle_like && !cancel && !select_valid && coin_valid;
    assign coin_sum    = {1'b0, credit} + {1'b0, coin_value(coin)};
    assign coin_accept = coin_arb && (coin != ILLEGALCOIN) && !coin_sum[CREDIT_W];
    assign sel_empty   = (stock[select] == '0);
    assign sel_poor    = (credit < price_tab[select]);
    assign sel_ok      = idle_like && !cancel && select_valid && !sel_empty && !sel_poor;
    assign vend_rem    = credit - price_tab[vend_item];
    assign change_rem  = credit - coin_value(greedy_coin(credit));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_CREDIT: begin
                if (cancel) begin
                    if (credit != '0)
                        state_next = S_CHANGE;
                end else if (sel_ok) begin
                    state_next = S_VEND;
                end else if (coin_accept) begin
                    state_next = S_CREDIT;
                end
            end
            S_VEND:   state_next = (vend_rem != '0) ? S_CHANGE : S_IDLE;
            S_CHANGE: state_next = (change_rem == '0) ? S_IDLE : S_CHANGE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dispense_valid = (state == S_VEND);
        change_valid   = (state == S_CHANGE);
        busy           = (state == S_VEND) || (state == S_CHANGE);
        dispense_item  = vend_item;
    end

    always_comb begin
        credit_next = credit;
        status_next = status;
        reject_next = coin_valid && !coin_accept;
        case (state)
            S_IDLE, S_CREDIT: begin
                if (cancel) begin
                    status_next = (credit != '0) ? AVAILABE : ERROR;
                end else if (select_valid) begin
                    if (sel_empty)
                        status_next = UNAVAILABLE;
                    else if (sel_poor)
                        status_next = ERROR;
                    else
                        status_next = AVAILABE;
                end else if (coin_valid) begin
                    if (coin == ILLEGALCOIN)
                        status_next = ERROR;
                    else if (coin_accept)
                        credit_next = coin_sum[CREDIT_W-1:0];
                end
            end
            S_VEND:   credit_next = vend_rem;
            S_CHANGE: credit_next = change_rem;
            default:  credit_next = credit;
        endcase
    end

    // Restock and the vend decrement of the same item combine before saturation.
    always_comb begin
        stock_sum = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_sum = {1'b0, stock[i]};
            if (restock_valid && (restock_item == SEL_W'(i)))
                stock_sum = stock_sum + {1'b0, restock_qty};
            if ((state == S_VEND) && (vend_item == SEL_W'(i)))
                stock_sum = stock_sum - (STOCK_W+1)'(1);
            stock_next[i] = (stock_sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : stock_sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit      <= '0;
            status      <= AVAILABE;
            coin_reject <= 1'b0;
            vend_item   <= '0;
            change_coin <= NICKEL;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i]       <= STOCK_W'(INIT_STOCK);
                stock_empty[i] <= (INIT_STOCK == 0);
            end
        end else begin
            credit      <= credit_next;
            status      <= status_next;
            coin_reject <= reject_next;
            change_coin <= greedy_coin(credit_next);
            if (sel_ok)
                vend_item <= select;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i]       <= stock_next[i];
                stock_empty[i] <= (stock_next[i] == '0);
            end
        end
    end

endmodule

// File: tb/tb_vm_controller.sv
// tb/tb_vm_controller.sv - randomized and directed checks of vm_controller against a transaction-level model
module tb_vm_controller;
    import vm2002_pkg::*;

    localparam int N    = 8;
    localparam int CW   = 8;
    localparam int SW   = 4;
    localparam int INIT = 2;
    localparam int CMAX = 255;
    localparam int SMAX = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         coin_valid;
    coin_t        coin;
    logic         coin_reject;
    logic         select_valid;
    logic [2:0]   sel;
    logic         cancel;
    logic         restock_valid;
    logic [2:0]   restock_item;
    logic [SW-1:0] restock_qty;
    logic [CW-1:0] credit;
    logic         dispense_valid;
    logic [2:0]   dispense_item;
    logic         change_valid;
    coin_t        change_coin;
    status_t      status;
    logic         busy;
    logic [N-1:0] stock_empty;

    vm_controller #(
        .NUM_ITEMS (N),
        .CREDIT_W  (CW),
        .STOCK_W   (SW),
        .INIT_STOCK(INIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin          (coin),
        .coin_reject   (coin_reject),
        .select_valid  (select_valid),
        .select        (sel),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .restock_qty   (restock_qty),
        .credit        (credit),
        .dispense_valid(dispense_valid),
        .dispense_item (dispense_item),
        .change_valid  (change_valid),
        .change_coin   (change_coin),
        .status        (status),
        .busy          (busy),
        .stock_empty   (stock_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Price list in item order, $0.05 units.
    int prices[N] = '{10, 20, 20, 40, 20, 25, 30, 35};

    int m_credit;
    int m_status;
    int m_reject;
    int m_stock[N];
    int q[$];          // pending busy cycles: 100+item = dispense, else coin code

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cval(input int c);
        if (c == int'(NICKEL))  return 1;
        if (c == int'(DIME))    return 2;
        if (c == int'(QUARTER)) return 5;
        return 0;
    endfunction

    task automatic push_change(input int amt);
        int a;
        a = amt;
        repeat (a / 5) q.push_back(int'(QUARTER));
        a = a % 5;
        repeat (a / 2) q.push_back(int'(DIME));
        if (a % 2 == 1) q.push_back(int'(NICKEL));
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_status = int'(AVAILABE);
        m_reject = 0;
        q.delete();
        for (int i = 0; i < N; i++) m_stock[i] = INIT;
    endtask

    task automatic model_edge(input int cv, input int c, input int sv, input int s,
                              input int cn, input int rv, input int ri, input int rq);
        int dec_item;
        int ev;
        int v;
        dec_item = -1;
        m_reject = 0;
        if (q.size() != 0) begin
            ev = q.pop_front();
            if (ev >= 100) begin
                m_credit -= prices[ev-100];
                dec_item  = ev - 100;
            end else begin
                m_credit -= cval(ev);
            end
            if (cv != 0) m_reject = 1;
        end else if (cn != 0) begin
            if (m_credit > 0) begin
                m_status = int'(AVAILABE);
                push_change(m_credit);
            end else begin
                m_status = int'(ERROR);
            end
            if (cv != 0) m_reject = 1;
        end else if (sv != 0) begin
            if (m_stock[s] == 0) begin
                m_status = int'(UNAVAILABLE);
            end else if (m_credit < prices[s]) begin
                m_status = int'(ERROR);
            end else begin
                m_status = int'(AVAILABE);
                q.push_back(100 + s);
                push_change(m_credit - prices[s]);
            end
            if (cv != 0) m_reject = 1;
        end else if (cv != 0) begin
            if (c == int'(ILLEGALCOIN)) begin
                m_reject = 1;
                m_status = int'(ERROR);
            end else if (m_credit + cval(c) > CMAX) begin
                m_reject = 1;
            end else begin
                m_credit += cval(c);
            end
        end
        for (int i = 0; i < N; i++) begin
            v = m_stock[i];
            if (i == dec_item) v = v - 1;
            if (rv != 0 && ri == i) v = v + rq;
            if (v > SMAX) v = SMAX;
            m_stock[i] = v;
        end
    endtask

    task automatic check_outputs();
        int head;
        logic [N-1:0] e_empty;
        head = (q.size() != 0) ? q[0] : -1;
        for (int i = 0; i < N; i++) e_empty[i] = (m_stock[i] == 0);
        chk("credit", 32'(credit), m_credit);
        chk("status", 32'(status), m_status);
        chk("coin_reject", 32'(coin_reject), m_reject);
        chk("busy", 32'(busy), (q.size() != 0) ? 1 : 0);
        chk("dispense_valid", 32'(dispense_valid), (head >= 100) ? 1 : 0);
        if (head >= 100) chk("dispense_item", 32'(dispense_item), head - 100);
        chk("change_valid", 32'(change_valid), (head >= 0 && head < 100) ? 1 : 0);
        if (head >= 0 && head < 100) chk("change_coin", 32'(change_coin), head);
        chk("stock_empty", 32'(stock_empty), 32'(e_empty));
    endtask

    task automatic tick(input int cv, input int c, input int sv, input int s,
                        input int cn, input int rv, input int ri, input int rq);
        coin_valid    = (cv != 0);
        coin          = coin_t'(2'(c));
        select_valid  = (sv != 0);
        sel           = 3'(s);
        cancel        = (cn != 0);
        restock_valid = (rv != 0);
        restock_item  = 3'(ri);
        restock_qty   = SW'(rq);
        @(posedge clk);
        model_edge(cv, c, sv, s, cn, rv, ri, rq);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic put(input int c);
        tick(1, c, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pick(input int s);
        tick(0, 0, 1, s, 0, 0, 0, 0);
    endtask

    task automatic cxl();
        tick(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            idle(1);
            k++;
        end
        idle(1);
    endtask

    localparam int QC = int'(QUARTER);
    localparam int DC = int'(DIME);
    localparam int NC = int'(NICKEL);
    localparam int IC = int'(ILLEGALCOIN);

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin = NICKEL; select_valid = 1'b0; sel = '0;
        cancel = 1'b0; restock_valid = 1'b0; restock_item = '0; restock_qty = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_credit", 32'(credit), 0);
        chk("rst_dispense_item", 32'(dispense_item), 0);
        chk("rst_change_coin", 32'(change_coin), NC);
        chk("rst_status", 32'(status), int'(AVAILABE));
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        idle(2);

        // exact payment, no change
        put(QC); put(QC); pick(0);
        chk("t1_dispense", 32'(dispense_valid), 1);
        idle(1);
        chk("t1_credit", 32'(credit), 0);
        chk("t1_no_change", 32'(change_valid), 0);

        // overpayment returns one quarter
        repeat (5) put(QC);
        pick(2); idle(1);
        chk("t2_change_coin", 32'(change_coin), QC);
        idle(1);
        chk("t2_credit", 32'(credit), 0);

        // insufficient credit, then refund
        put(DC); pick(0);
        chk("t3_status", 32'(status), int'(ERROR));
        chk("t3_credit", 32'(credit), 2);
        cxl();
        chk("t3_refund_coin", 32'(change_coin), DC);
        drain();

        // refund sequence with coin during change
        put(QC); put(DC); put(NC); cxl();
        chk("t4_first", 32'(change_coin), QC);
        put(NC);
        chk("t4_second", 32'(change_coin), DC);
        chk("t4_reject", 32'(coin_reject), 1);
        idle(1);
        chk("t4_third", 32'(change_coin), NC);
        drain();

        // stock exhaustion and same-cycle restock with vend
        repeat (4) put(QC);
        pick(1); drain();
        repeat (4) put(QC);
        pick(1);
        tick(0, 0, 0, 0, 0, 1, 1, 3);
        chk("t5_not_empty", 32'(stock_empty[1]), 0);
        repeat (3) begin
            repeat (4) put(QC);
            pick(1); drain();
        end
        repeat (4) put(QC);
        pick(1);
        chk("t5_unavail", 32'(status), int'(UNAVAILABLE));
        chk("t5_empty", 32'(stock_empty[1]), 1);
        chk("t5_credit_kept", 32'(credit), 20);
        cxl(); drain();

        // illegal coin, credit overflow
        put(IC);
        chk("t6_illegal_reject", 32'(coin_reject), 1);
        chk("t6_illegal_status", 32'(status), int'(ERROR));
        repeat (50) put(QC);
        put(DC); put(DC);
        put(DC);
        chk("t6_ovf_reject", 32'(coin_reject), 1);
        chk("t6_ovf_credit", 32'(credit), 254);

        // asynchronous reset mid-change
        cxl(); idle(2);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_credit", 32'(credit), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_change", 32'(change_valid), 0);
        chk("t6_rst_stock", 32'(stock_empty), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        idle(2);

        // randomized traffic
        repeat (3000) begin
            tick(($urandom_range(0, 9) < 4) ? 1 : 0, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 2) ? 1 : 0, int'($urandom_range(0, N-1)),
                 ($urandom_range(0, 19) == 0) ? 1 : 0,
                 ($urandom_range(0, 19) == 0) ? 1 : 0, int'($urandom_range(0, N-1)),
                 int'($urandom_range(0, 3)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
